// File: rtl/efuse_array_model_if.sv
// Pin bundle between an eFuse controller (master) and the fuse macro model (slave).
// Carries the pgenb/nr/strobe/we request side plus read data, debug contents and error flags.
interface efuse_array_model_if #(
    parameter int M = 32
);
    logic         pgenb;
    logic         nr;
    logic         strobe;
    logic [M-1:0] we;
    logic         q;
    logic [M-1:0] fuse_bits;
    logic         blow_pulse;
    logic         err_mode;
    logic         err_sel;
    logic         err_short;
    logic         err_we_chg;

    modport master (
        output pgenb, nr, strobe, we,
        input  q, fuse_bits, blow_pulse, err_mode, err_sel, err_short, err_we_chg
    );

    modport slave (
        input  pgenb, nr, strobe, we,
        output q, fuse_bits, blow_pulse, err_mode, err_sel, err_short, err_we_chg
    );
endinterface

// File: rtl/efuse_array_model.sv
// Responder model of an M-bit one-time-programmable eFuse macro: serves reads, blows a bit
// on a sufficiently long program strobe, and raises sticky flags on protocol violations.
module efuse_array_model #(
    parameter int         M         = 32,
    parameter int         T_PGM_MIN = 20,
    parameter logic [M-1:0] INIT_VAL = '0
) (
    input  logic                 clk_div2,
    input  logic                 rst,
    efuse_array_model_if.slave   bus
);
    localparam int CW = $clog2(T_PGM_MIN + 1);

    typedef enum logic [1:0] {MODE_IDLE, MODE_READ, MODE_PGM, MODE_ILLEGAL} mode_t;
    typedef enum logic [1:0] {P_IDLE, P_ARM, P_DONE} pgm_state_t;

    mode_t        w_mode;
    logic         w_onehot;
    logic         w_strobe_rise;

    pgm_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [M-1:0] r_sel;
    logic [M-1:0] r_fuse;
    logic         r_strobe_d;
    logic         r_q;
    logic         r_blow;
    logic         r_err_mode;
    logic         r_err_sel;
    logic         r_err_short;
    logic         r_err_we_chg;

    always_comb begin
        w_mode = MODE_IDLE;
        case ({bus.pgenb, bus.nr})
            2'b10:   w_mode = MODE_IDLE;
            2'b11:   w_mode = MODE_READ;
            2'b00:   w_mode = MODE_PGM;
            default: w_mode = MODE_ILLEGAL;
        endcase
    end

    assign w_onehot      = (bus.we != '0) && ((bus.we & (bus.we - M'(1))) == '0);
    assign w_strobe_rise = bus.strobe && !r_strobe_d;

    always_ff @(posedge clk_div2 or posedge rst) begin
        if (rst) begin
            r_state      <= P_IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_fuse       <= INIT_VAL;
            r_strobe_d   <= 1'b0;
            r_q          <= 1'b0;
            r_blow       <= 1'b0;
            r_err_mode   <= 1'b0;
            r_err_sel    <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_we_chg <= 1'b0;
        end else begin
            r_strobe_d <= bus.strobe;
            r_blow     <= 1'b0;
            r_q        <= (w_mode == MODE_READ && bus.strobe && w_onehot) ? |(r_fuse & bus.we) : 1'b0;

            if (w_mode == MODE_ILLEGAL)
                r_err_mode <= 1'b1;
            if (bus.strobe && !w_onehot)
                r_err_sel <= 1'b1;

            case (r_state)
                P_IDLE: begin
                    if (w_mode == MODE_PGM && w_strobe_rise && w_onehot) begin
                        r_state <= P_ARM;
                        r_sel   <= bus.we;
                        r_cnt   <= CW'(1);
                    end
                end
                P_ARM: begin
                    // Dropping out of program mode mid-pulse counts as a truncated pulse.
                    if (w_mode != MODE_PGM) begin
                        r_state     <= P_IDLE;
                        r_err_short <= 1'b1;
                    end else if (bus.strobe) begin
                        if (bus.we != r_sel) begin
                            r_state      <= P_IDLE;
                            r_err_we_chg <= 1'b1;
                        end else if (r_cnt < CW'(T_PGM_MIN)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        if (r_cnt >= CW'(T_PGM_MIN)) begin
                            r_fuse <= r_fuse | r_sel;
                            r_blow <= 1'b1;
                        end else begin
                            r_err_short <= 1'b1;
                        end
                        r_state <= P_DONE;
                    end
                end
                P_DONE:  r_state <= P_IDLE;
                default: r_state <= P_IDLE;
            endcase
        end
    end

    assign bus.q          = r_q;
    assign bus.fuse_bits  = r_fuse;
    assign bus.blow_pulse = r_blow;
    assign bus.err_mode   = r_err_mode;
    assign bus.err_sel    = r_err_sel;
    assign bus.err_short  = r_err_short;
    assign bus.err_we_chg = r_err_we_chg;
endmodule
